rv32i_instr_encoder: RTL
========================

// Module: rv32i_instr_encoder
// PURPOSE
//  Inverse of the RV32I decode path. Accepts symbolic ops (op enum, rd, rs1, rs2, 32-bit imm)
//  over valid/ready, range-checks the immediate, packs the RV32I word and writes it to
//  instruction memory at an auto-incrementing address. Used by the boot/self-test loader
//  to build programs in IMEM without an external assembler.
// PARAMETERS
//  ADDR_W  12  byte-address width of the IMEM write port; address wraps modulo 2**ADDR_W
//  CNT_W   16  width of instr_count (saturating)
// PORTS
//  clk         in   1       system clock
//  reset       in   1       synchronous, active-high reset
//  start       in   1       load base_addr, clear instr_count, abort any pending word
//  base_addr   in   ADDR_W  first write address; bits [1:0] forced to 0
//  in_valid    in   1       request valid
//  in_ready    out  1       request accepted when in_valid && in_ready
//  in_op       in   6       op enum (rv32i_enc_pkg)
//  in_rd/in_rs1/in_rs2 in 5 register indices (ignored where format lacks the field)
//  in_imm      in   32      immediate as signed value; U-type = full 32-bit value
//  mem_w       out  1       IMEM write strobe, held until mem_ready
//  mem_addr    out  ADDR_W  IMEM byte address
//  mem_data    out  32      encoded instruction
//  mem_ready   in   1       IMEM accepts write when mem_w && mem_ready
//  imm_err     out  1       1-cycle pulse: request rejected (bad op or imm out of range)
//  instr_count out  CNT_W   words written since start/reset
//  busy        out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, mem_w=0, mem_addr=0, mem_data=0, imm_err=0, instr_count=0.
//  FSM IDLE -> ENCODE -> WRITE -> IDLE. in_ready = (state==IDLE) && !start.
//  IDLE: on accept, latch op/fields into holding reg -> ENCODE.
//  ENCODE (1 cycle): pack + check. Pass: mem_data<=word, mem_w<=1 -> WRITE.
//   Fail: imm_err=1 for this cycle, no write, address/count unchanged -> IDLE.
//  WRITE: mem_w/mem_addr/mem_data stable until mem_ready; on handshake mem_w<=0,
//   mem_addr+=4 (wraps to 0 past 2**ADDR_W-4), instr_count+=1 (saturate) -> IDLE.
//  Latency: accept cycle N -> mem_w high in cycle N+2. Max throughput 1 word / 3 cycles.
//  Range rules: I/load/S/JALR signed 12-bit [-2048,2047]; B signed 13-bit, bit0=0;
//   J signed 21-bit, bit0=0; U imm[11:0]=0; SLLI/SRLI/SRAI imm in [0,31]; R-type imm ignored.
//   Undefined op enum -> imm_err.
//  Fields: opcode/fn3/fn7 per RV32I; SRAI/SRA fn7=0100000, SUB fn7=0100000; FENCE pred/succ
//   from imm[7:0], fm=0.
//  start: priority over everything in any state; drops holding reg and mem_w, reloads
//   mem_addr, clears count, -> IDLE next cycle. Reset mid-write: same, all to reset values.
//  mem_ready while mem_w=0 ignored.
// CONFIGURATION
//  ZIHINTPAUSE_EN defined: op OP_PAUSE encodes 0x0100000F (FENCE pred=W, succ=0, fm=0,
//   rd=rs1=x0), fields ignored. Undefined: OP_PAUSE is an undefined op -> imm_err, no write.
// STRUCTURE
//  rv32i_enc_pkg: OP_* enum localparams (LUI..AND, FENCE, PAUSE), 7-bit opcode constants,
//   fn3/fn7 constants, format codes FMT_R/I/S/B/U/J/SH.
//  Sub-module rv32i_enc_pack: combinational op+fields -> {word[31:0], err}; FSM, address,
//   counter and handshake stay in top.
// TESTING
//  1 reset; start base=0x100; ADDI rd=1 rs1=0 imm=5 -> mem_w at N+2, addr 0x100, data 0x00500093
//  2 BEQ rs1=1 rs2=2 imm=-8 -> data 0xFE208CE3 at 0x104; LUI rd=5 imm=0x12345000 -> 0x123452B7
//  3 ADDI imm=2048 -> imm_err 1 cycle, no mem_w, next write still at 0x108, count unchanged
//  4 mem_ready low 5 cycles -> mem_w/addr/data stable, in_ready=0; write completes on cycle 6
//  5 ADDR_W=8, base 0xFC, two ADDIs -> addrs 0xFC then 0x00; start during WRITE -> no write
//  6 OP_PAUSE with ZIHINTPAUSE_EN -> 0x0100000F; without -> imm_err, no write

Source files
------------

// File: rtl/rv32i_enc_pkg.sv
// Shared constants for the RV32I instruction encoder: op enum, opcodes,
// function fields, instruction formats and the encoder FSM state type.
package rv32i_enc_pkg;

    localparam logic [5:0] OP_LUI   = 6'd0;
    localparam logic [5:0] OP_AUIPC = 6'd1;
    localparam logic [5:0] OP_JAL   = 6'd2;
    localparam logic [5:0] OP_JALR  = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_BLT   = 6'd6;
    localparam logic [5:0] OP_BGE   = 6'd7;
    localparam logic [5:0] OP_BLTU  = 6'd8;
    localparam logic [5:0] OP_BGEU  = 6'd9;
    localparam logic [5:0] OP_LB    = 6'd10;
    localparam logic [5:0] OP_LH    = 6'd11;
    localparam logic [5:0] OP_LW    = 6'd12;
    localparam logic [5:0] OP_LBU   = 6'd13;
    localparam logic [5:0] OP_LHU   = 6'd14;
    localparam logic [5:0] OP_SB    = 6'd15;
    localparam logic [5:0] OP_SH    = 6'd16;
    localparam logic [5:0] OP_SW    = 6'd17;
    localparam logic [5:0] OP_ADDI  = 6'd18;
    localparam logic [5:0] OP_SLTI  = 6'd19;
    localparam logic [5:0] OP_SLTIU = 6'd20;
    localparam logic [5:0] OP_XORI  = 6'd21;
    localparam logic [5:0] OP_ORI   = 6'd22;
    localparam logic [5:0] OP_ANDI  = 6'd23;
    localparam logic [5:0] OP_SLLI  = 6'd24;
    localparam logic [5:0] OP_SRLI  = 6'd25;
    localparam logic [5:0] OP_SRAI  = 6'd26;
    localparam logic [5:0] OP_ADD   = 6'd27;
    localparam logic [5:0] OP_SUB   = 6'd28;
    localparam logic [5:0] OP_SLL   = 6'd29;
    localparam logic [5:0] OP_SLT   = 6'd30;
    localparam logic [5:0] OP_SLTU  = 6'd31;
    localparam logic [5:0] OP_XOR   = 6'd32;
    localparam logic [5:0] OP_SRL   = 6'd33;
    localparam logic [5:0] OP_SRA   = 6'd34;
    localparam logic [5:0] OP_OR    = 6'd35;
    localparam logic [5:0] OP_AND   = 6'd36;
    localparam logic [5:0] OP_FENCE = 6'd37;
    localparam logic [5:0] OP_PAUSE = 6'd38;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;
    localparam logic [2:0] F3_B    = 3'd0;
    localparam logic [2:0] F3_H    = 3'd1;
    localparam logic [2:0] F3_W    = 3'd2;
    localparam logic [2:0] F3_BU   = 3'd4;
    localparam logic [2:0] F3_HU   = 3'd5;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH
    } fmt_e;

    typedef enum logic [1:0] {
        S_IDLE, S_ENCODE, S_WRITE
    } enc_state_e;

endpackage

// File: rtl/rv32i_enc_pack.sv
// Combinational op + fields -> RV32I word and reject flag.
// ZIHINTPAUSE_EN enables OP_PAUSE; otherwise it is treated as an undefined op.
module rv32i_enc_pack
    import rv32i_enc_pkg::*;
(
    input  logic [5:0]         op,
    input  logic [4:0]         rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic signed [31:0] imm,
    output logic [31:0]        word,
    output logic               err
);

    fmt_e               fmt;
    logic [6:0]         opc;
    logic [2:0]         fn3;
    logic [6:0]         fn7;
    logic               known;
    logic               range_ok;
    logic [4:0]         rd_f;
    logic [4:0]         rs1_f;
    logic signed [31:0] imm_f;

    always_comb begin
        fmt   = FMT_R;
        opc   = '0;
        fn3   = '0;
        fn7   = F7_BASE;
        known = 1'b1;
        rd_f  = rd;
        rs1_f = rs1;
        imm_f = imm;
        case (op)
            OP_LUI:   begin fmt = FMT_U;  opc = OPC_LUI;   end
            OP_AUIPC: begin fmt = FMT_U;  opc = OPC_AUIPC; end
            OP_JAL:   begin fmt = FMT_J;  opc = OPC_JAL;   end
            OP_JALR:  begin fmt = FMT_I;  opc = OPC_JALR;   fn3 = F3_ADD;  end
            OP_BEQ:   begin fmt = FMT_B;  opc = OPC_BRANCH; fn3 = F3_BEQ;  end
            OP_BNE:   begin fmt = FMT_B;  opc = OPC_BRANCH; fn3 = F3_BNE;  end
            OP_BLT:   begin fmt = FMT_B;  opc = OPC_BRANCH; fn3 = F3_BLT;  end
            OP_BGE:   begin fmt = FMT_B;  opc = OPC_BRANCH; fn3 = F3_BGE;  end
            OP_BLTU:  begin fmt = FMT_B;  opc = OPC_BRANCH; fn3 = F3_BLTU; end
            OP_BGEU:  begin fmt = FMT_B;  opc = OPC_BRANCH; fn3 = F3_BGEU; end
            OP_LB:    begin fmt = FMT_I;  opc = OPC_LOAD;   fn3 = F3_B;    end
            OP_LH:    begin fmt = FMT_I;  opc = OPC_LOAD;   fn3 = F3_H;    end
            OP_LW:    begin fmt = FMT_I;  opc = OPC_LOAD;   fn3 = F3_W;    end
            OP_LBU:   begin fmt = FMT_I;  opc = OPC_LOAD;   fn3 = F3_BU;   end
            OP_LHU:   begin fmt = FMT_I;  opc = OPC_LOAD;   fn3 = F3_HU;   end
            OP_SB:    begin fmt = FMT_S;  opc = OPC_STORE;  fn3 = F3_B;    end
            OP_SH:    begin fmt = FMT_S;  opc = OPC_STORE;  fn3 = F3_H;    end
            OP_SW:    begin fmt = FMT_S;  opc = OPC_STORE;  fn3 = F3_W;    end
            OP_ADDI:  begin fmt = FMT_I;  opc = OPC_OPIMM;  fn3 = F3_ADD;  end
            OP_SLTI:  begin fmt = FMT_I;  opc = OPC_OPIMM;  fn3 = F3_SLT;  end
            OP_SLTIU: begin fmt = FMT_I;  opc = OPC_OPIMM;  fn3 = F3_SLTU; end
            OP_XORI:  begin fmt = FMT_I;  opc = OPC_OPIMM;  fn3 = F3_XOR;  end
            OP_ORI:   begin fmt = FMT_I;  opc = OPC_OPIMM;  fn3 = F3_OR;   end
            OP_ANDI:  begin fmt = FMT_I;  opc = OPC_OPIMM;  fn3 = F3_AND;  end
            OP_SLLI:  begin fmt = FMT_SH; opc = OPC_OPIMM;  fn3 = F3_SLL;  end
            OP_SRLI:  begin fmt = FMT_SH; opc = OPC_OPIMM;  fn3 = F3_SR;   end
            OP_SRAI:  begin fmt = FMT_SH; opc = OPC_OPIMM;  fn3 = F3_SR;  fn7 = F7_ALT; end
            OP_ADD:   begin fmt = FMT_R;  opc = OPC_OP;     fn3 = F3_ADD;  end
            OP_SUB:   begin fmt = FMT_R;  opc = OPC_OP;     fn3 = F3_ADD; fn7 = F7_ALT; end
            OP_SLL:   begin fmt = FMT_R;  opc = OPC_OP;     fn3 = F3_SLL;  end
            OP_SLT:   begin fmt = FMT_R;  opc = OPC_OP;     fn3 = F3_SLT;  end
            OP_SLTU:  begin fmt = FMT_R;  opc = OPC_OP;     fn3 = F3_SLTU; end
            OP_XOR:   begin fmt = FMT_R;  opc = OPC_OP;     fn3 = F3_XOR;  end
            OP_SRL:   begin fmt = FMT_R;  opc = OPC_OP;     fn3 = F3_SR;   end
            OP_SRA:   begin fmt = FMT_R;  opc = OPC_OP;     fn3 = F3_SR;  fn7 = F7_ALT; end
            OP_OR:    begin fmt = FMT_R;  opc = OPC_OP;     fn3 = F3_OR;   end
            OP_AND:   begin fmt = FMT_R;  opc = OPC_OP;     fn3 = F3_AND;  end
            // FENCE keeps only pred/succ; fm, rd and rs1 are always zero
            OP_FENCE: begin
                fmt   = FMT_I;
                opc   = OPC_MISC;
                rd_f  = '0;
                rs1_f = '0;
                imm_f = {24'd0, imm[7:0]};
            end
`ifdef ZIHINTPAUSE_EN
            OP_PAUSE: begin
                fmt   = FMT_I;
                opc   = OPC_MISC;
                rd_f  = '0;
                rs1_f = '0;
                imm_f = 32'sh0000_0010;
            end
`endif
            default:  known = 1'b0;
        endcase
    end

    always_comb begin
        word     = '0;
        range_ok = 1'b0;
        case (fmt)
            FMT_R: begin
                range_ok = 1'b1;
                word     = {fn7, rs2, rs1_f, fn3, rd_f, opc};
            end
            FMT_I: begin
                range_ok = (imm_f[31:11] == {21{imm_f[11]}});
                word     = {imm_f[11:0], rs1_f, fn3, rd_f, opc};
            end
            FMT_SH: begin
                range_ok = (imm_f[31:5] == 27'd0);
                word     = {fn7, imm_f[4:0], rs1_f, fn3, rd_f, opc};
            end
            FMT_S: begin
                range_ok = (imm_f[31:11] == {21{imm_f[11]}});
                word     = {imm_f[11:5], rs2, rs1_f, fn3, imm_f[4:0], opc};
            end
            FMT_B: begin
                range_ok = (imm_f[31:12] == {20{imm_f[12]}}) && !imm_f[0];
                word     = {imm_f[12], imm_f[10:5], rs2, rs1_f, fn3,
                            imm_f[4:1], imm_f[11], opc};
            end
            FMT_U: begin
                range_ok = (imm_f[11:0] == 12'd0);
                word     = {imm_f[31:12], rd_f, opc};
            end
            FMT_J: begin
                range_ok = (imm_f[31:20] == {12{imm_f[20]}}) && !imm_f[0];
                word     = {imm_f[20], imm_f[10:1], imm_f[11], imm_f[19:12], rd_f, opc};
            end
            default: range_ok = 1'b0;
        endcase
        err = !known || !range_ok;
    end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// RV32I encoder front end: valid/ready request intake, encode/check, IMEM write
// with auto-incrementing address. ZIHINTPAUSE_EN (see rv32i_enc_pack) enables OP_PAUSE.
module rv32i_instr_encoder
    import rv32i_enc_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              mem_w,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    input  logic              mem_ready,
    output logic              imm_err,
    output logic [CNT_W-1:0]  instr_count,
    output logic              busy
);

    enc_state_e         state;
    logic [5:0]         op_p0;
    logic [4:0]         rd_p0;
    logic [4:0]         rs1_p0;
    logic [4:0]         rs2_p0;
    logic signed [31:0] imm_p0;
    logic [31:0]        word_p1;
    logic               err_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign in_ready = (state == S_IDLE) && !start;
    assign busy     = (state != S_IDLE);

    // Stage p0: request holding register, loaded only on an accepted handshake
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            op_p0  <= in_op;
            rd_p0  <= in_rd;
            rs1_p0 <= in_rs1;
            rs2_p0 <= in_rs2;
            imm_p0 <= $signed(in_imm);
        end
    end

    // Stage p1: pack and range check, consumed by the FSM during ENCODE
    rv32i_enc_pack u_pack (
        .op   (op_p0),
        .rd   (rd_p0),
        .rs1  (rs1_p0),
        .rs2  (rs2_p0),
        .imm  (imm_p0),
        .word (word_p1),
        .err  (err_p1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            mem_w       <= 1'b0;
            mem_addr    <= '0;
            mem_data    <= '0;
            imm_err     <= 1'b0;
            instr_count <= '0;
        end else if (start) begin
            state       <= S_IDLE;
            mem_w       <= 1'b0;
            mem_addr    <= {base_addr[ADDR_W-1:2], 2'b00};
            imm_err     <= 1'b0;
            instr_count <= '0;
        end else begin
            imm_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) state <= S_ENCODE;
                end
                S_ENCODE: begin
                    if (err_p1) begin
                        imm_err <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        mem_data <= word_p1;
                        mem_w    <= 1'b1;
                        state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        mem_w       <= 1'b0;
                        mem_addr    <= mem_addr + ADDR_W'(4);
                        instr_count <= sat_inc(instr_count);
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
